// File: rtl/ucie_sb_tx_serializer_if.sv
`default_nettype none
//==============================================================================
// Module   : ucie_sb_tx_serializer_if
// Brief    : Word push handshake from the sideband link controller to the TX serializer
// Revision : 1.0
//==============================================================================
interface ucie_sb_tx_serializer_if #(
  parameter int PKT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_data;
  logic             in_last;

  modport master (output in_valid, output in_data, output in_last, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface
`default_nettype wire

// File: rtl/ucie_sb_tx_serializer.sv
`default_nettype none
//==============================================================================
// Module   : ucie_sb_tx_serializer
// Brief    : UCIe sideband TX path; word FIFO feeding an LSB-first shifter with a gated SBTX_CLK
// Revision : 1.0
//==============================================================================
module ucie_sb_tx_serializer #(
  parameter int PKT_W      = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int HALF_DIV   = 1,
  parameter int GAP_UI     = 32
) (
  input  wire logic                          clk,
  input  wire logic                          sb_reset_n,
  input  wire logic                          tx_en,
  ucie_sb_tx_serializer_if.slave             in_if,
  output logic                               SBTX_CLK,
  output logic                               SBTX_DATA,
  output logic                               busy,
  output logic                               pkt_done,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               ovf_err
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W   = c_PTR_W + 1;
  localparam int c_BIT_W   = $clog2(PKT_W);
  localparam int c_PH_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int c_GAP_CYC = GAP_UI * 2 * HALF_DIV;
  localparam int c_GAP_W   = (c_GAP_CYC > 1) ? $clog2(c_GAP_CYC) : 1;

  localparam logic [c_LVL_W-1:0] c_DEPTH    = c_LVL_W'(FIFO_DEPTH);
  localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(HALF_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(PKT_W - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(c_GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // FIFO storage: bit PKT_W carries the word's in_last flag
  logic [PKT_W:0]       r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_count;

  state_t               r_state;
  logic [PKT_W-1:0]     r_shift;
  logic                 r_last;
  logic                 r_wait;
  logic                 r_phase;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [c_PH_W-1:0]    r_ph_cnt;
  logic [c_GAP_W-1:0]   r_gap_cnt;

  state_t               w_state_nxt;
  logic [PKT_W-1:0]     w_shift_nxt;
  logic                 w_last_nxt;
  logic                 w_wait_nxt;
  logic                 w_phase_nxt;
  logic [c_BIT_W-1:0]   w_bit_nxt;
  logic [c_PH_W-1:0]    w_ph_nxt;
  logic [c_GAP_W-1:0]   w_gap_nxt;
  logic                 w_sbclk_nxt;
  logic                 w_sbdat_nxt;
  logic                 w_done_nxt;
  logic                 w_load;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic [PKT_W:0]       w_head;
  logic [c_BIT_W-1:0]   w_bit_inc;

  assign w_full          = (r_count == c_DEPTH);
  assign w_empty         = (r_count == '0);
  assign in_if.in_ready  = !w_full;
  assign w_push          = in_if.in_valid && !w_full;
  assign w_head          = r_mem[r_rd_ptr];
  assign w_bit_inc       = r_bit_cnt + 1'b1;
  assign fifo_level      = r_count;
  assign busy            = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_if.in_last, in_if.in_data};
    end
  end

  // A full FIFO rejects the write even when the shifter pops in the same cycle
  always_ff @(posedge clk) begin
    if (!sb_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + c_LVL_W'(w_push) - c_LVL_W'(w_load);
      if (in_if.in_valid && w_full) begin
        ovf_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_last_nxt  = r_last;
    w_wait_nxt  = r_wait;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit_cnt;
    w_ph_nxt    = r_ph_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_sbclk_nxt = SBTX_CLK;
    w_sbdat_nxt = SBTX_DATA;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (tx_en && !w_empty) begin
          w_load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_wait) begin
          // Underrun inside a packet: pads stay low until the next word shows up
          if (!w_empty) begin
            w_load = 1'b1;
          end
        end else if (r_ph_cnt != c_PH_LAST) begin
          w_ph_nxt = r_ph_cnt + 1'b1;
        end else begin
          w_ph_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
            w_sbclk_nxt = 1'b1;
          end else if (r_bit_cnt != c_BIT_LAST) begin
            w_bit_nxt   = w_bit_inc;
            w_phase_nxt = 1'b0;
            w_sbclk_nxt = 1'b0;
            w_sbdat_nxt = r_shift[w_bit_inc];
          end else begin
            w_phase_nxt = 1'b0;
            w_sbclk_nxt = 1'b0;
            w_sbdat_nxt = 1'b0;
            if (r_last) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = '0;
            end else if (!w_empty) begin
              w_load = 1'b1;
            end else begin
              w_wait_nxt = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_state_nxt = S_SHIFT;
      w_shift_nxt = w_head[PKT_W-1:0];
      w_last_nxt  = w_head[PKT_W];
      w_wait_nxt  = 1'b0;
      w_phase_nxt = 1'b0;
      w_bit_nxt   = '0;
      w_ph_nxt    = '0;
      w_sbclk_nxt = 1'b0;
      w_sbdat_nxt = w_head[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!sb_reset_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_last    <= 1'b0;
      r_wait    <= 1'b0;
      r_phase   <= 1'b0;
      r_bit_cnt <= '0;
      r_ph_cnt  <= '0;
      r_gap_cnt <= '0;
      SBTX_CLK  <= 1'b0;
      SBTX_DATA <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_last    <= w_last_nxt;
      r_wait    <= w_wait_nxt;
      r_phase   <= w_phase_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_ph_cnt  <= w_ph_nxt;
      r_gap_cnt <= w_gap_nxt;
      SBTX_CLK  <= w_sbclk_nxt;
      SBTX_DATA <= w_sbdat_nxt;
      pkt_done  <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucie_sb_tx_serializer.sv
`default_nettype none
//==============================================================================
// Module   : tb_ucie_sb_tx_serializer
// Brief    : Bench with a pad-level receiver model decoding SBTX_CLK/SBTX_DATA into words
// Revision : 1.0
//==============================================================================
module tb_ucie_sb_tx_serializer;
  localparam int PKT_W      = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF_DIV   = 1;
  localparam int GAP_UI     = 32;
  localparam int GAP_CYC    = GAP_UI * 2 * HALF_DIV;
  localparam int UI_CYC     = 2 * HALF_DIV;

  logic clk = 1'b0;
  logic sb_reset_n = 1'b0;
  logic tx_en = 1'b0;
  logic SBTX_CLK, SBTX_DATA, busy, pkt_done, ovf_err;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  ucie_sb_tx_serializer_if #(.PKT_W(PKT_W)) bus ();

  ucie_sb_tx_serializer #(
    .PKT_W(PKT_W), .FIFO_DEPTH(FIFO_DEPTH), .HALF_DIV(HALF_DIV), .GAP_UI(GAP_UI)
  ) dut (
    .clk(clk), .sb_reset_n(sb_reset_n), .tx_en(tx_en), .in_if(bus),
    .SBTX_CLK(SBTX_CLK), .SBTX_DATA(SBTX_DATA), .busy(busy), .pkt_done(pkt_done),
    .fifo_level(fifo_level), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Receiver model state
  int cyc = 0, rx_bits = 0, words_in_pkt = 0, rises_in_pkt = 0, last_rise = -1000;
  int rise_total = 0, done_total = 0, gap_viol = 0, space_viol = 0;
  bit allow_underrun = 1'b0;
  logic prev_clk = 1'b0;
  logic [PKT_W-1:0] rx_word;
  logic [PKT_W-1:0] rx_q[$];
  int               len_q[$];
  logic [PKT_W-1:0] exp_q[$];
  int               exp_len_q[$];

  // Sideband receiver: latches data on each SBTX_CLK rise, LSB first
  initial begin : receiver
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (sb_reset_n !== 1'b1) begin
        rx_bits = 0; words_in_pkt = 0; rises_in_pkt = 0; prev_clk = 1'b0;
      end else begin
        if (SBTX_CLK === 1'b1 && prev_clk === 1'b0) begin
          if (rises_in_pkt > 0 && !allow_underrun && (cyc - last_rise) != UI_CYC) space_viol++;
          rx_word[rx_bits] = SBTX_DATA;
          rx_bits++; rises_in_pkt++; rise_total++; last_rise = cyc;
          if (rx_bits == PKT_W) begin
            rx_q.push_back(rx_word); rx_bits = 0; words_in_pkt++;
          end
        end
        if (pkt_done === 1'b1) begin
          done_total++;
          len_q.push_back(words_in_pkt);
          if ((cyc - last_rise) != HALF_DIV + GAP_CYC) gap_viol++;
          words_in_pkt = 0; rises_in_pkt = 0;
        end
        prev_clk = SBTX_CLK;
      end
    end
  end

  task automatic push_word(input logic [PKT_W-1:0] d, input logic l);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    while (bus.in_ready !== 1'b1 && waited < 3000) begin
      @(negedge clk); waited++;
    end
    checks++;
    if (waited >= 3000) begin
      errors++;
      $display("FAIL push_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, waited);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_total < target && n < budget) begin
      @(negedge clk); n++;
    end
    checks++;
    if (done_total < target) begin
      errors++;
      $display("FAIL %s_done_timeout: pkt_done count %0d, required %0d", tag, done_total, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    sb_reset_n = 1'b0; tx_en = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom}; bus.in_last = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({SBTX_CLK, SBTX_DATA} !== 2'b00) begin errors++; $display("FAIL reset_pads: got %b required 00", {SBTX_CLK, SBTX_DATA}); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d required 0", fifo_level); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", ovf_err); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", bus.in_ready); end
    checks++; if ({busy, pkt_done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b required 00", {busy, pkt_done}); end
    bus.in_valid = 1'b0; sb_reset_n = 1'b1;
    @(negedge clk);
    checks++; if (fifo_level !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset_no_write: level %0d busy %b, required 0 0", fifo_level, busy); end
    tx_en = 1'b0;
  endtask

  task automatic test_single();
    int d0, r0;
    d0 = done_total; r0 = rise_total;
    tx_en = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 64'h5; bus.in_last = 1'b1;
    exp_q.push_back(64'h5); exp_len_q.push_back(1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (fifo_level !== 1) begin errors++; $display("FAIL single_level_e0: got %0d required 1", fifo_level); end
    @(negedge clk);
    checks++; if ({SBTX_CLK, SBTX_DATA} !== 2'b01) begin errors++; $display("FAIL single_bit0_low: got %b required 01", {SBTX_CLK, SBTX_DATA}); end
    checks++; if (fifo_level !== 0) begin errors++; $display("FAIL single_pop: level %0d required 0", fifo_level); end
    repeat (HALF_DIV) @(negedge clk);
    checks++; if ({SBTX_CLK, SBTX_DATA} !== 2'b11) begin errors++; $display("FAIL single_bit0_high: got %b required 11", {SBTX_CLK, SBTX_DATA}); end
    repeat (HALF_DIV) @(negedge clk);
    checks++; if ({SBTX_CLK, SBTX_DATA} !== 2'b00) begin errors++; $display("FAIL single_bit1_low: got %b required 00", {SBTX_CLK, SBTX_DATA}); end
    wait_done(d0 + 1, 600, "single");
    checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL single_done_seen: got %b required 1", pkt_done); end
    checks++; if (rise_total - r0 != PKT_W) begin errors++; $display("FAIL single_rises: got %0d required %0d", rise_total - r0, PKT_W); end
    @(negedge clk);
    checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b required 0", pkt_done); end
  endtask

  task automatic test_two_word();
    int d0, r0;
    logic [PKT_W-1:0] a, b;
    d0 = done_total; r0 = rise_total;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    exp_q.push_back(a); exp_q.push_back(b); exp_len_q.push_back(2);
    push_word(a, 1'b0);
    push_word(b, 1'b1);
    wait_done(d0 + 1, 800, "two_word");
    repeat (100) @(negedge clk);
    checks++; if (rise_total - r0 != 2 * PKT_W) begin errors++; $display("FAIL two_word_rises: got %0d required %0d", rise_total - r0, 2 * PKT_W); end
    checks++; if (done_total != d0 + 1) begin errors++; $display("FAIL two_word_done_count: got %0d required %0d", done_total - d0, 1); end
  endtask

  task automatic test_overflow();
    int lvl, d0;
    logic exp_ready;
    logic [PKT_W-1:0] w;
    tx_en = 1'b0; lvl = 0; d0 = done_total;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      w = {$urandom, $urandom};
      bus.in_valid = 1'b1; bus.in_data = w; bus.in_last = 1'b1;
      exp_ready = (lvl < FIFO_DEPTH);
      checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL ovf_ready_%0d: got %b required %b", i, bus.in_ready, exp_ready); end
      if (i == FIFO_DEPTH) begin
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b required 0", ovf_err); end
      end
      if (exp_ready) begin
        lvl++; exp_q.push_back(w); exp_len_q.push_back(1);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", ovf_err); end
    checks++; if (fifo_level !== lvl) begin errors++; $display("FAIL ovf_level: got %0d required %0d", fifo_level, lvl); end
    tx_en = 1'b1;
    wait_done(d0 + lvl, 2000, "ovf_drain");
    @(negedge clk);
    checks++; if (fifo_level !== 0 || ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_after_drain: level %0d ovf %b, required 0 1", fifo_level, ovf_err); end
  endtask

  task automatic test_tx_en_pause();
    int d0, d1, r1;
    logic [PKT_W-1:0] a0, a1, b;
    d0 = done_total; tx_en = 1'b1;
    a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom}; b = {$urandom, $urandom};
    exp_q.push_back(a0); exp_q.push_back(a1); exp_q.push_back(b);
    exp_len_q.push_back(2); exp_len_q.push_back(1);
    push_word(a0, 1'b0); push_word(a1, 1'b1); push_word(b, 1'b1);
    repeat (10) @(negedge clk);
    tx_en = 1'b0;
    wait_done(d0 + 1, 800, "pause_first");
    d1 = done_total; r1 = rise_total;
    repeat (300) @(negedge clk);
    checks++; if (rise_total != r1 || done_total != d1) begin errors++; $display("FAIL pause_quiet: rises %0d done %0d, required 0 0", rise_total - r1, done_total - d1); end
    checks++; if (fifo_level !== 1 || busy !== 1'b1) begin errors++; $display("FAIL pause_held: level %0d busy %b, required 1 1", fifo_level, busy); end
    tx_en = 1'b1;
    wait_done(d1 + 1, 600, "pause_second");
  endtask

  task automatic test_underrun();
    int d0, r0;
    logic [PKT_W-1:0] w0, w1;
    d0 = done_total; r0 = rise_total; allow_underrun = 1'b1; tx_en = 1'b1;
    w0 = {$urandom, $urandom}; w1 = {$urandom, $urandom};
    exp_q.push_back(w0); exp_q.push_back(w1); exp_len_q.push_back(2);
    push_word(w0, 1'b0);
    repeat (250) @(negedge clk);
    checks++; if ({SBTX_CLK, SBTX_DATA, busy} !== 3'b001) begin errors++; $display("FAIL underrun_hold: clk/data/busy %b required 001", {SBTX_CLK, SBTX_DATA, busy}); end
    checks++; if (rise_total - r0 != PKT_W || done_total != d0) begin errors++; $display("FAIL underrun_progress: rises %0d done %0d, required %0d 0", rise_total - r0, done_total - d0, PKT_W); end
    push_word(w1, 1'b1);
    wait_done(d0 + 1, 600, "underrun");
    allow_underrun = 1'b0;
  endtask

  task automatic test_random_packets();
    int d0, n, len;
    logic [PKT_W-1:0] w;
    d0 = done_total; tx_en = 1'b1;
    n = 6;
    for (int p = 0; p < n; p++) begin
      len = $urandom_range(1, 3);
      exp_len_q.push_back(len);
      for (int k = 0; k < len; k++) begin
        w = {$urandom, $urandom};
        exp_q.push_back(w);
        push_word(w, (k == len - 1));
      end
    end
    wait_done(d0 + n, 6000, "random");
  endtask

  task automatic test_reset_mid();
    int d1, r1, n;
    logic [PKT_W-1:0] z;
    tx_en = 1'b1;
    push_word({$urandom, $urandom}, 1'b1);
    push_word({$urandom, $urandom}, 1'b1);
    n = 0;
    while (rx_bits < 20 && n < 500) begin @(negedge clk); n++; end
    checks++; if (rx_bits < 20) begin errors++; $display("FAIL rstmid_reach_bit20: got %0d bits required 20", rx_bits); end
    sb_reset_n = 1'b0;
    @(negedge clk);
    checks++; if ({SBTX_CLK, SBTX_DATA, pkt_done} !== 3'b000) begin errors++; $display("FAIL rstmid_pads: got %b required 000", {SBTX_CLK, SBTX_DATA, pkt_done}); end
    checks++; if (fifo_level !== 0 || busy !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL rstmid_state: level %0d busy %b ovf %b, required 0 0 0", fifo_level, busy, ovf_err); end
    sb_reset_n = 1'b1;
    d1 = done_total; r1 = rise_total;
    repeat (150) @(negedge clk);
    checks++; if (done_total != d1 || rise_total != r1) begin errors++; $display("FAIL rstmid_abandon: done %0d rises %0d, required 0 0", done_total - d1, rise_total - r1); end
    z = {$urandom, $urandom};
    exp_q.push_back(z); exp_len_q.push_back(1);
    push_word(z, 1'b1);
    wait_done(d1 + 1, 600, "rstmid_new");
  endtask

  task automatic test_stream_integrity();
    int nw, np;
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL stream_word_count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    nw = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < nw; i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_word_%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (len_q.size() != exp_len_q.size()) begin errors++; $display("FAIL stream_pkt_count: got %0d required %0d", len_q.size(), exp_len_q.size()); end
    np = (len_q.size() < exp_len_q.size()) ? len_q.size() : exp_len_q.size();
    for (int i = 0; i < np; i++) begin
      checks++; if (len_q[i] != exp_len_q[i]) begin errors++; $display("FAIL stream_pkt_len_%0d: got %0d required %0d", i, len_q[i], exp_len_q[i]); end
    end
    checks++; if (gap_viol != 0) begin errors++; $display("FAIL gap_length: %0d packets with wrong gap, required 0", gap_viol); end
    checks++; if (space_viol != 0) begin errors++; $display("FAIL ui_spacing: %0d irregular clock rises, required 0", space_viol); end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    test_reset();
    test_single();
    test_two_word();
    test_overflow();
    test_tx_en_pause();
    test_underrun();
    test_random_packets();
    test_reset_mid();
    test_stream_integrity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
